led_seq_engine: RTL

Parametrised LED pattern sequencer for the board's LED bank and RGB LEDs. Generalises the fixed four-LED flash/shift/pair sequencer to NB_LEDS outputs, adds a programmable step rate and a ping-pong (bounce) mode, and routes the pattern to the plain LED bank and to one selectable RGB colour channel. It sits directly under the top level, fed by the switches and buttons, and drives the LED pins.

---
 rtl/led_seq_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/led_seq_engine.sv
// LED pattern sequencer: FLASH / SHIFT / PAIR / BOUNCE modes, programmable step rate, RGB channel routing.
// Optional button debounce filter enabled by defining LED_SEQ_DEBOUNCE_EN.
module led_seq_engine #(
    parameter int NB_LEDS         = 4,
    parameter int NB_COUNTER      = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_dir,
    input  logic [1:0]         i_speed,
    input  logic               i_mode_btn,
    input  logic [1:0]         i_color_sel,
    output logic [NB_LEDS-1:0] o_led,
    output logic [NB_LEDS-1:0] o_led_r,
    output logic [NB_LEDS-1:0] o_led_g,
    output logic [NB_LEDS-1:0] o_led_b,
    output logic [1:0]         o_mode,
    output logic               o_tick
);

    localparam int HALF = NB_LEDS / 2;
    localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [NB_LEDS-1:0] ONE = NB_LEDS'(1);

    typedef enum logic [1:0] {
        FLASH  = 2'd0,
        SHIFT  = 2'd1,
        PAIR   = 2'd2,
        BOUNCE = 2'd3
    } mode_t;

    mode_t                  mode, mode_n;
    logic [NB_COUNTER-1:0]  cnt, cnt_n, limit;
    logic [NB_LEDS-1:0]     pat, pat_n;
    logic [NB_LEDS-1:0]     led_r, led_g, led_b, r_n, g_n, b_n;
    logic [KW-1:0]          k, k_n;
    logic                   up, up_n;
    logic                   tick, tick_n;
    logic                   step, press;

    function automatic logic [NB_LEDS-1:0] pair_pattern(input logic [KW-1:0] idx);
        pair_pattern = (ONE << (HALF - 1 - int'(idx))) | (ONE << (HALF + int'(idx)));
    endfunction

    // Button edge detection: press is a one-cycle pulse on the rising edge of the (filtered) level.
`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          btn_d1, filt, filt_q;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            btn_d1 <= 1'b0;
            filt   <= 1'b0;
            filt_q <= 1'b0;
            db_cnt <= '0;
        end else begin
            btn_d1 <= i_mode_btn;
            filt_q <= filt;
            if (btn_d1 != filt) begin
                if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    filt   <= btn_d1;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = filt & ~filt_q;
`else
    logic btn_d1, btn_d2;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            btn_d1 <= 1'b0;
            btn_d2 <= 1'b0;
        end else begin
            btn_d1 <= i_mode_btn;
            btn_d2 <= btn_d1;
        end
    end

    assign press = btn_d1 & ~btn_d2;
`endif

    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt   <= '0;
            mode  <= FLASH;
            pat   <= '0;
            k     <= '0;
            up    <= 1'b0;
            tick  <= 1'b0;
            led_r <= '0;
            led_g <= '0;
            led_b <= '0;
        end else begin
            cnt   <= cnt_n;
            mode  <= mode_n;
            pat   <= pat_n;
            k     <= k_n;
            up    <= up_n;
            tick  <= tick_n;
            led_r <= r_n;
            led_g <= g_n;
            led_b <= b_n;
        end
    end

    always_comb begin
        limit  = {NB_COUNTER{1'b1}} >> {i_speed, 1'b0};
        step   = i_enable && (cnt >= limit);
        cnt_n  = cnt;
        mode_n = mode;
        pat_n  = pat;
        k_n    = k;
        up_n   = up;
        tick_n = 1'b0;

        if (i_enable) begin
            cnt_n = step ? '0 : cnt + 1'b1;
        end

        if (press) begin
            mode_n = mode_t'(mode + 2'd1);
            k_n    = '0;
            up_n   = 1'b1;
            case (mode_n)
                FLASH:   pat_n = '0;
                SHIFT:   pat_n = ONE << (NB_LEDS - 1);
                PAIR:    pat_n = pair_pattern('0);
                default: pat_n = ONE;
            endcase
        end else if (step) begin
            tick_n = 1'b1;
            case (mode)
                FLASH: pat_n = ~pat;
                SHIFT: begin
                    if (i_dir) pat_n = {pat[NB_LEDS-2:0], pat[NB_LEDS-1]};
                    else       pat_n = {pat[0], pat[NB_LEDS-1:1]};
                end
                PAIR: begin
                    if (i_dir) k_n = (k == '0) ? KW'(HALF - 1) : k - 1'b1;
                    else       k_n = (k == KW'(HALF - 1)) ? '0 : k + 1'b1;
                    pat_n = pair_pattern(k_n);
                end
                default: begin
                    // Direction flips as the lit bit lands on an end, so the end is lit for one step only.
                    if (up) begin
                        pat_n = pat << 1;
                        if (pat[NB_LEDS-2]) up_n = 1'b0;
                    end else begin
                        pat_n = pat >> 1;
                        if (pat[1]) up_n = 1'b1;
                    end
                end
            endcase
        end

        r_n = (i_color_sel == 2'd1) ? pat_n : '0;
        g_n = (i_color_sel == 2'd2) ? pat_n : '0;
        b_n = (i_color_sel == 2'd3) ? pat_n : '0;
    end

    assign o_led   = pat;
    assign o_led_r = led_r;
    assign o_led_g = led_g;
    assign o_led_b = led_b;
    assign o_mode  = mode;
    assign o_tick  = tick;

endmodule
